seg_scan: RTL and testbench
===========================

# seg_scan

Multiplexed 8-digit seven-segment scanner sitting directly downstream of the display clock divider. It consumes the divider's slow square wave as a scan strobe and time-multiplexes a latched 32-bit hex value onto shared segment lines, one digit per strobe. A programmable all-off gap between digits suppresses ghosting. Shadow registers latched once per frame prevent tearing.

## Interface
- GAP, 4, clk cycles of all-anodes-off between digits; legal range 1..255
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- segclk_i  in  1  scan strobe from divider (asynchronous to clk in principle); each rising edge advances one digit
- data_i  in  32  eight hex nibbles; nibble k = data_i[4k+3:4k] drives digit k
- dp_i  in  8  decimal point per digit, 1 = lit
- en_i  in  8  digit enable, 0 = digit forced dark
- lzs_i  in  1  leading-zero suppression enable
- an_o  out  8  anode selects, active-low, at most one low
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low
- frame_o  out  1  one-cycle pulse when a new frame is latched

## Operation
- Strobe path: segclk_i → 2-FF synchronizer → delay FF; tick = sync_out & ~delay. One tick per segclk_i rising edge; falling edges ignored.
- Digit index idx (3 bits) wraps 7 → 0. Reset value 7, so the first tick selects digit 0.
- Frame latch: on a tick that moves idx to 0, capture data_i, dp_i, en_i, lzs_i into shadow registers and pulse frame_o. All display content comes only from shadows; mid-frame input changes appear next frame.
- States: HOLD (drive current digit, or all off after reset), BLANK (all off, gap counter running).
  - HOLD + tick → BLANK, gap counter loaded with GAP-1, idx advances.
  - BLANK, counter > 0 → decrement.
  - BLANK, counter = 0 → HOLD, drive digit idx.
  - Tick while in BLANK: ignored entirely (no idx advance, no frame latch).
- Digit dark (an_o bit stays 1) when shadow en[idx]=0, or when suppressed.
- Leading-zero suppression (shadow lzs=1): digit k is suppressed iff nibbles k..7 are all 0. Digit 0 is never suppressed. The decimal point of a suppressed digit is also dark.
- Decoder, seg_o as {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Dark or blank digit: seg_o=7'h7F, dp_o=1. Lit digit: dp_o = ~dp[idx].

## Timing
- Reset (asynchronous, immediate): an_o=8'hFF, seg_o=7'h7F, dp_o=1, frame_o=0, state HOLD with all off, idx=7, synchronizer/delay FFs=0, shadows=0, gap counter=0.
- All outputs registered. segclk_i rising, setup met before clk edge E0 → tick high after E1 → at E2 an_o=FF, idx advances, and frame_o=1 if wrapping. frame_o returns to 0 at E3.
- Digit drive (an_o, seg_o, dp_o together, one clk edge) occurs GAP cycles after the blank edge, i.e. at E2+GAP.
- an_o and seg_o never change on different edges for the same digit; no cycle has two anodes low.
- segclk_i high/low phases each must exceed GAP+3 clk cycles for every edge to be honoured. Faster edges are dropped per the BLANK-ignore rule.

## Test plan
- Reset: hold rst=0 with random inputs → an_o=FF, seg_o=7F, dp_o=1, frame_o=0. Release with segclk_i static → outputs unchanged.
- Full frame, GAP=4: data_i=32'h1234ABCD, dp_i=8'h01, en_i=FF, 8 strobes.
  - First strobe: frame_o pulse.
  - Digit 0: an_o=FE, seg_o=0100001 ('d'), dp_o=0.
  - Digit 7: an_o=7F, seg_o=1111001 ('1').
  - Exactly 4 all-off cycles before each digit.
- No tearing: change data_i to 32'hFFFFFFFF after the digit-2 strobe → digits 3..7 still show 1234A's digits. The new value appears only after the next wrap's frame_o.
- Suppression: data_i=32'h000000A0, lzs_i=1 → digits 7..2 dark (an_o stays FF in their slots), digit 1='A', digit 0='0'. Same data with lzs_i=0 → all eight lit.
- Enable/strobe rate: en_i=8'h0F → digits 4..7 dark. A second segclk_i rising edge arriving during BLANK → no extra advance, idx sequence unchanged.
- Async reset mid-gap: assert rst=0 between clk edges during BLANK → outputs reach reset values before the next clk edge. After release, the first strobe selects digit 0 and pulses frame_o.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed seven-segment scanner with
// inter-digit blanking and a once-per-frame shadow latch.
module seg_scan #(
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        segclk_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        lzs_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  typedef enum logic {HOLD, BLANK} state_t;

  localparam logic [7:0] GAP_LD = 8'(GAP - 1);

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        dly;
  logic        tick;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [7:0]  cnt;
  logic [31:0] sh_data;
  logic [7:0]  sh_dp;
  logic [7:0]  sh_en;
  logic        sh_lzs;
  logic [3:0]  nib;
  logic        sup;
  logic        lit;
  logic [6:0]  glyph;

  assign tick    = sync2 & ~dly;
  assign idx_nxt = idx + 3'd1;
  assign nib     = sh_data[{idx, 2'b00} +: 4];

  // Suppressed when this digit and every higher one is zero.
  assign sup = sh_lzs && (idx != 3'd0) &&
               ((sh_data >> {idx, 2'b00}) == 32'd0);
  assign lit = sh_en[idx] && !sup;

  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      dly     <= 1'b0;
      state   <= HOLD;
      idx     <= 3'd7;
      cnt     <= 8'd0;
      sh_data <= 32'd0;
      sh_dp   <= 8'd0;
      sh_en   <= 8'd0;
      sh_lzs  <= 1'b0;
      an_o    <= 8'hFF;
      seg_o   <= 7'h7F;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      sync1   <= segclk_i;
      sync2   <= sync1;
      dly     <= sync2;
      frame_o <= 1'b0;
      unique case (state)
        HOLD: begin
          if (tick) begin
            state <= BLANK;
            cnt   <= GAP_LD;
            idx   <= idx_nxt;
            an_o  <= 8'hFF;
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
            if (idx_nxt == 3'd0) begin
              sh_data <= data_i;
              sh_dp   <= dp_i;
              sh_en   <= en_i;
              sh_lzs  <= lzs_i;
              frame_o <= 1'b1;
            end
          end
        end
        BLANK: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= HOLD;
            if (lit) begin
              an_o  <= ~(8'd1 << idx);
              seg_o <= glyph;
              dp_o  <= ~sh_dp[idx];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed frames against a cycle-level
// behavioural model of the scanner plus literal spot checks.
module tb_seg_scan;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        segclk_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic [7:0]  en_i = '0;
  logic        lzs_i = 1'b0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int passed = 0;
  int total  = 0;

  seg_scan #(.GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .segclk_i (segclk_i),
    .data_i   (data_i),
    .dp_i     (dp_i),
    .en_i     (en_i),
    .lzs_i    (lzs_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
  endtask

  // Behavioural model: segclk samples per edge, a blanking
  // countdown, and shadow copies of the inputs.
  bit          s1, s2, s3, m_tick, m_sup;
  int          m_idx, m_gap;
  logic [31:0] m_data;
  logic [7:0]  m_dp, m_en;
  logic        m_lzs;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 = 0; s2 = 0; s3 = 0;
      m_idx = 7; m_gap = 0;
      m_data = '0; m_dp = '0; m_en = '0; m_lzs = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1; e_frame = 0;
    end else begin
      m_tick = s2 && !s3;
      s3 = s2; s2 = s1; s1 = segclk_i;
      e_frame = 0;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          m_sup = m_lzs && (m_idx != 0);
          for (int k = m_idx; k < 8; k++)
            if (m_data[4*k +: 4] != 4'h0) m_sup = 0;
          if (m_en[m_idx] && !m_sup) begin
            e_an = 8'hFF;
            e_an[m_idx] = 1'b0;
            e_seg = seg_tab[m_data[4*m_idx +: 4]];
            e_dp = ~m_dp[m_idx];
          end
        end
      end else if (m_tick) begin
        m_idx = (m_idx + 1) % 8;
        if (m_idx == 0) begin
          m_data = data_i; m_dp = dp_i;
          m_en = en_i; m_lzs = lzs_i;
          e_frame = 1;
        end
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1;
        m_gap = GAP;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("model_an", an_o, e_an);
      check("model_seg", seg_o, e_seg);
      check("model_dp", dp_o, e_dp);
      check("model_frame", frame_o, e_frame);
    end
  end

  bit         r_lit [8];
  logic [7:0] r_an  [8];
  logic [6:0] r_seg [8];
  logic       r_dp  [8];
  int         r_offs[8];
  bit         r_frm [8];

  task automatic strobe(input bit glitch,
                        output bit lit, output logic [7:0] an,
                        output logic [6:0] seg, output logic dp,
                        output int offs, output bit frm);
    lit = 0; an = 8'hFF; seg = 7'h7F; dp = 1;
    offs = 0; frm = 0;
    @(negedge clk);
    segclk_i = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (glitch && i == 2) segclk_i = 0;
      if (glitch && i == 3) segclk_i = 1;
      if (frame_o) frm = 1;
      if (an_o == 8'hFF) offs++;
      else if (i >= 2 && !lit) begin
        lit = 1; an = an_o; seg = seg_o; dp = dp_o;
      end
    end
    segclk_i = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input int glitch_at, input int change_at);
    for (int k = 0; k < 8; k++) begin
      strobe(k == glitch_at, r_lit[k], r_an[k], r_seg[k],
             r_dp[k], r_offs[k], r_frm[k]);
      if (k == change_at) data_i = 32'hFFFF_FFFF;
    end
  endtask

  bit         x_lit, x_frm;
  logic [7:0] x_an;
  logic [6:0] x_seg;
  logic       x_dp;
  int         x_offs;

  initial begin
    data_i = $urandom; dp_i = 8'($urandom);
    en_i = 8'($urandom); lzs_i = 1'($urandom);
    repeat (3) @(negedge clk);
    check("rst_an", an_o, 8'hFF);
    check("rst_seg", seg_o, 7'h7F);
    check("rst_dp", dp_o, 1'b1);
    check("rst_frame", frame_o, 1'b0);

    data_i = 32'h1234_ABCD; dp_i = 8'h01;
    en_i = 8'hFF; lzs_i = 0;
    rst = 1;
    repeat (5) @(negedge clk);
    check("idle_an", an_o, 8'hFF);
    check("idle_seg", seg_o, 7'h7F);

    frame(-1, 2);
    check("f1_frame", r_frm[0], 1'b1);
    check("f1_d0_an", r_an[0], 8'hFE);
    check("f1_d0_seg", r_seg[0], 7'b0100001);
    check("f1_d0_dp", r_dp[0], 1'b0);
    check("f1_d1_frame", r_frm[1], 1'b0);
    check("f1_d3_seg", r_seg[3], 7'b0001000);
    check("f1_d7_an", r_an[7], 8'h7F);
    check("f1_d7_seg", r_seg[7], 7'b1111001);
    check("f1_d7_dp", r_dp[7], 1'b1);
    for (int k = 1; k < 8; k++)
      check("f1_gap_cycles", r_offs[k], GAP);

    frame(-1, -1);
    check("f2_frame", r_frm[0], 1'b1);
    check("f2_d0_seg", r_seg[0], 7'b0001110);
    check("f2_d0_dp", r_dp[0], 1'b0);

    data_i = 32'h0000_00A0; lzs_i = 1; dp_i = 8'h00;
    frame(-1, -1);
    for (int k = 2; k < 8; k++)
      check("f3_suppressed", r_lit[k], 1'b0);
    check("f3_d1_an", r_an[1], 8'hFD);
    check("f3_d1_seg", r_seg[1], 7'b0001000);
    check("f3_d0_seg", r_seg[0], 7'b1000000);
    check("f3_d0_dp", r_dp[0], 1'b1);

    lzs_i = 0;
    frame(-1, -1);
    for (int k = 0; k < 8; k++)
      check("f4_all_lit", r_lit[k], 1'b1);
    check("f4_d7_seg", r_seg[7], 7'b1000000);

    data_i = 32'h1234_ABCD; en_i = 8'h0F;
    frame(1, -1);
    check("f5_d1_an", r_an[1], 8'hFD);
    check("f5_d2_an", r_an[2], 8'hFB);
    check("f5_d3_an", r_an[3], 8'hF7);
    for (int k = 4; k < 8; k++)
      check("f5_disabled", r_lit[k], 1'b0);

    @(negedge clk);
    segclk_i = 1;
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    #1;
    check("async_an", an_o, 8'hFF);
    check("async_seg", seg_o, 7'h7F);
    check("async_dp", dp_o, 1'b1);
    check("async_frame", frame_o, 1'b0);
    segclk_i = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    strobe(0, x_lit, x_an, x_seg, x_dp, x_offs, x_frm);
    check("post_rst_frame", x_frm, 1'b1);
    check("post_rst_an", x_an, 8'hFE);
    check("post_rst_seg", x_seg, 7'b0100001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
